// File: rtl/axis_sched_pkg.sv
// Shared definitions for the AXI-Stream frame scheduler: FSM state encoding
// and the tid width helper.
package axis_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARB    = 2'd1,
        ACTIVE = 2'd2
    } sched_state_e;

    // A single port still needs one tid bit.
    function automatic int id_width(input int ports);
        return (ports <= 2) ? 1 : $clog2(ports);
    endfunction

endpackage

// File: rtl/axis_frame_scheduler_rr_select.sv
// Cyclic priority search: first requester found after last_grant, wrapping
// around the port range. Purely combinational.
module rr_select #(
    parameter int PORTS    = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [PORTS-1:0]    req,
    input  logic [ID_WIDTH-1:0] last_grant,
    output logic [ID_WIDTH-1:0] grant,
    output logic                any_request
);

    logic [ID_WIDTH-1:0] idx;

    // Walk from the farthest candidate back to the nearest so the nearest hit wins.
    always_comb begin
        grant       = '0;
        any_request = 1'b0;
        idx         = '0;
        for (int i = PORTS; i >= 1; i--) begin
            idx = ID_WIDTH'((int'(last_grant) + i) % PORTS);
            if (req[idx]) begin
                grant       = idx;
                any_request = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_frame_scheduler.sv
// Round-robin AXI-Stream scheduler: grants one input port for a block of
// `rate` frames and forwards its beats through a single output register.
module axis_frame_scheduler
    import axis_sched_pkg::*;
#(
    parameter int  DATA_WIDTH = 16,
    parameter int  PORTS      = 4,
    parameter int  RATE_WIDTH = 8,
    localparam int ID_WIDTH   = id_width(PORTS)
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [RATE_WIDTH-1:0]       rate,
    input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]            s_axis_tvalid,
    input  logic [PORTS-1:0]            s_axis_tlast,
    output logic [PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    output logic [ID_WIDTH-1:0]         m_axis_tid,
    output logic                        m_axis_tuser,
    input  logic                        m_axis_tready,
    output logic                        busy
);

    sched_state_e          state_q, state_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;
    logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic [RATE_WIDTH-1:0] rate_q, rate_d;
    logic [RATE_WIDTH-1:0] cnt_q, cnt_d;
    logic                  first_q, first_d;

    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [ID_WIDTH-1:0]   tid_q, tid_d;
    logic                  tuser_q, tuser_d;

    logic [ID_WIDTH-1:0]   rr_grant;
    logic                  rr_any;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid, in_last;
    logic                  out_ready, beat_acc;

    rr_select #(
        .PORTS    (PORTS),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_select (
        .req         (s_axis_tvalid),
        .last_grant  (last_grant_q),
        .grant       (rr_grant),
        .any_request (rr_any)
    );

    always_comb begin
        in_data       = '0;
        in_valid      = 1'b0;
        in_last       = 1'b0;
        s_axis_tready = '0;
        out_ready     = !tvalid_q || m_axis_tready;
        for (int p = 0; p < PORTS; p++) begin
            if (grant_q == ID_WIDTH'(p)) begin
                in_data  = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
                in_valid = s_axis_tvalid[p];
                in_last  = s_axis_tlast[p];
                s_axis_tready[p] = (state_q == ACTIVE) && out_ready;
            end
        end
        beat_acc = (state_q == ACTIVE) && out_ready && in_valid;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        rate_d       = rate_q;
        cnt_d        = cnt_q;
        first_d      = first_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        tid_d        = tid_q;
        tuser_d      = tuser_q;

        // Output register drains on its own, regardless of FSM state.
        if (m_axis_tready) tvalid_d = 1'b0;
        if (beat_acc) begin
            tdata_d  = in_data;
            tlast_d  = in_last;
            tid_d    = grant_q;
            tuser_d  = first_q;
            tvalid_d = 1'b1;
            first_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (|s_axis_tvalid) state_d = ARB;
            end
            ARB: begin
                if (rr_any) begin
                    grant_d = rr_grant;
                    rate_d  = (rate == '0) ? RATE_WIDTH'(1) : rate;
                    cnt_d   = '0;
                    first_d = 1'b1;
                    state_d = ACTIVE;
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (beat_acc && in_last) begin
                    cnt_d = cnt_q + RATE_WIDTH'(1);
                    if (cnt_q == rate_q - RATE_WIDTH'(1)) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_WIDTH'(PORTS - 1);
            rate_q       <= RATE_WIDTH'(1);
            cnt_q        <= '0;
            first_q      <= 1'b0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tid_q        <= '0;
            tuser_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            rate_q       <= rate_d;
            cnt_q        <= cnt_d;
            first_q      <= first_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tid_q        <= tid_d;
            tuser_q      <= tuser_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tid    = tid_q;
    assign m_axis_tuser  = tuser_q;
    assign busy          = (state_q == ACTIVE);

endmodule

// File: doc/axis_frame_scheduler.md
AXIS_FRAME_SCHEDULER -- requirements
Module: axis_frame_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sample width per stream.
REQ-002 Parameter PORTS, default 4, number of requesting input streams, range 2..16.
REQ-003 Parameter RATE_WIDTH, default 8, width of the frames-per-grant field; matches the downstream accumulator's rate width.
REQ-004 Derived ID_WIDTH = max(1, clog2(PORTS)).
REQ-005 Ports (name, direction, width, meaning):
  - aclk, in, 1, single clock; all logic on its rising edge.
  - aresetn, in, 1, reset, asynchronous assert, active-low.
  - rate, in, RATE_WIDTH, frames per grant block.
  - s_axis_tdata, in, PORTS*DATA_WIDTH, packed per-port data; port p uses bits [p*DATA_WIDTH +: DATA_WIDTH].
  - s_axis_tvalid, in, PORTS, per-port valid.
  - s_axis_tlast, in, PORTS, per-port end of frame.
  - s_axis_tready, out, PORTS, per-port ready.
  - m_axis_tdata, out, DATA_WIDTH, granted stream data.
  - m_axis_tvalid, out, 1, output valid.
  - m_axis_tlast, out, 1, output end of frame.
  - m_axis_tid, out, ID_WIDTH, index of the source port for the beat.
  - m_axis_tuser, out, 1, first beat of a grant block.
  - m_axis_tready, in, 1, output ready.
  - busy, out, 1, high in ACTIVE.

Function
REQ-006 The FSM SHALL have exactly three states: IDLE, ARB and ACTIVE.
REQ-007 IDLE SHALL move to ARB on the first cycle in which any s_axis_tvalid bit is high.
REQ-008 ARB SHALL take exactly one cycle and then move to ACTIVE:
  - grant = first requesting port searched cyclically from (last_grant+1) mod PORTS;
  - latch rate into rate_q, with rate 0 treated as 1;
  - clear the frame counter;
  - if no port is still requesting in ARB, return to IDLE with no grant.
REQ-009 In ACTIVE, s_axis_tready[grant] SHALL be (!m_axis_tvalid || m_axis_tready); every other ready bit SHALL be 0. All ready bits SHALL be 0 in IDLE and ARB.
REQ-010 The output SHALL be a single register stage: an accepted input beat appears on m_axis_* on the next cycle, a latency of 1.
REQ-011 tdata, tlast and tid SHALL be held stable while m_axis_tvalid && !m_axis_tready.
REQ-012 m_axis_tid SHALL equal the grant for every beat.
REQ-013 m_axis_tuser SHALL be 1 only on the first beat accepted after entering ACTIVE.
REQ-014 The frame counter SHALL increment on each accepted beat with tlast=1.
REQ-015 On the accepted tlast at which counter == rate_q-1, the FSM SHALL:
  - go to IDLE;
  - store last_grant = grant;
  - deassert the grant ready in the same cycle that beat is accepted.
REQ-016 A grant SHALL be held for the whole block, even if the granted port deasserts tvalid mid-frame; there is no timeout.
REQ-017 A change on rate during ACTIVE SHALL have no effect until the next ARB.
REQ-018 The arbitration overhead between consecutive blocks SHALL be 2 cycles (IDLE, ARB), including when the same sole requester is re-granted.
REQ-019 The output register SHALL drain independently of the FSM: a pending output beat SHALL NOT block the transition to IDLE or ARB.
REQ-020 No beat SHALL be dropped or duplicated, and beats from different ports SHALL never interleave within a block.

Reset
REQ-021 While aresetn=0, the block SHALL force: state=IDLE, last_grant=PORTS-1 (so port 0 wins first), counter=0, rate_q=1.
REQ-022 While aresetn=0, all outputs SHALL be 0: m_axis_tvalid, tlast, tuser, tid, tdata, s_axis_tready and busy.
REQ-023 Reset asserted mid-frame SHALL discard the in-flight beat and block; after release, arbitration SHALL restart from port 0 priority.

Structure
REQ-024 A shared package axis_sched_pkg SHALL hold the FSM state enum (IDLE, ARB, ACTIVE) and a function computing ID_WIDTH.
REQ-025 The cyclic priority search SHALL be a sub-module rr_select: request vector plus last_grant in, grant index and any_request out, purely combinational. All state SHALL remain in axis_frame_scheduler.

Verification
REQ-026 Single port: rate=3, port 2 sends 3 frames of 4 beats with m_axis_tready=1 -> 12 output beats, tid=2, tuser only on beat 1, tlast on beats 4/8/12, busy drops after beat 12 is accepted.
REQ-027 Contention: all 4 ports valid, rate=1, 1-beat frames -> grant order 0,1,2,3,0, with 2 idle cycles between blocks.
REQ-028 Backpressure: m_axis_tready toggling 1,0,0,1 during a block -> output held stable while stalled, no loss, input ready low during the stall.
REQ-029 rate=0 -> exactly 1 frame per grant; rate changed from 2 to 5 mid-block -> the current block still ends after 2 frames.
REQ-030 Reset mid-frame: aresetn low for 1 cycle during beat 2 of a port 3 frame, with ports 1 and 3 requesting -> all outputs 0 immediately; next grant goes to port 1.
REQ-031 Granted port drops tvalid for 5 cycles mid-frame while port 0 is valid -> grant is held; port 0 is not served until the block completes.
